// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and default sizing.
package serial_adder_pkg;

    localparam int unsigned DefaultWidth = 8;
    localparam int unsigned DefaultCntW  = 5;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

endpackage

// File: rtl/serial_adder_fa_cell.sv
// Combinational 1-bit full adder built from two half adders and an OR.
module serial_adder_fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic ha1_s;
    logic ha1_c;
    logic ha2_c;

    assign ha1_s = a ^ b;
    assign ha1_c = a & b;
    assign s     = ha1_s ^ ci;
    assign ha2_c = ha1_s & ci;
    assign co    = ha1_c | ha2_c;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder with start/done handshake, one bit pair per clock.
// Defining SERIAL_ADDER_SUB_EN adds a sub port that turns the operation into x - y.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth,
    parameter int unsigned CNT_W = DefaultCntW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             c_in,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             busy,
    output logic             done
);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_sr_q, a_sr_d;
    logic [WIDTH-1:0]   b_sr_q, b_sr_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               carry_q, carry_d;
    logic               c_out_q, c_out_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [WIDTH-1:0]   b_load;
    logic               carry_load;
    logic               fa_s;
    logic               fa_co;

    // Subtraction is x + ~y + 1, so only the captured B operand and carry differ.
`ifdef SERIAL_ADDER_SUB_EN
    assign b_load     = sub ? ~y : y;
    assign carry_load = sub ? 1'b1 : c_in;
`else
    assign b_load     = y;
    assign carry_load = c_in;
`endif

    serial_adder_fa_cell u_fa (
        .a  (a_sr_q[0]),
        .b  (b_sr_q[0]),
        .ci (carry_q),
        .s  (fa_s),
        .co (fa_co)
    );

    always_comb begin
        state_d = state_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        sum_d   = sum_q;
        count_d = count_q;
        carry_d = carry_q;
        c_out_d = c_out_q;

        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    a_sr_d  = x;
                    b_sr_d  = b_load;
                    carry_d = carry_load;
                    count_d = '0;
                    sum_d   = '0;
                    state_d = StRun;
                end else begin
                    state_d = StIdle;
                end
            end
            StRun: begin
                carry_d = fa_co;
                sum_d   = {fa_s, sum_q[WIDTH-1:1]};
                a_sr_d  = a_sr_q >> 1;
                b_sr_d  = b_sr_q >> 1;
                count_d = count_q + CNT_W'(1);
                if (count_q == CNT_W'(WIDTH - 1)) begin
                    c_out_d = fa_co;
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d == StRun);
        done_d = (state_d == StDone);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            sum_q   <= '0;
            count_q <= '0;
            carry_q <= 1'b0;
            c_out_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            sum_q   <= sum_d;
            count_q <= count_d;
            carry_q <= carry_d;
            c_out_q <= c_out_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign sum   = sum_q;
    assign c_out = c_out_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule
